// File: rtl/twoscomp_pulse_seq.sv
// twoscomp_pulse_seq: start/busy initiator that walks a one-hot tp pulse, captures S/Cout, offers it on valid/ready.
// Define TWOSCOMP_SEQ_GAP_EN to insert one all-zero tp cycle between consecutive pulse bits.
module twoscomp_pulse_seq #(
  parameter int Width = 64,
  parameter int Pulse_Width = 21*Width,
  parameter int PULSE_LEN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  input  logic [Width-1:0]       a_in,
  input  logic [Width-1:0]       b_in,
  input  logic                   ca_in,
  output logic [Width-1:0]       op_a,
  output logic [Width-1:0]       op_b,
  output logic                   op_ca,
  output logic [Pulse_Width-1:0] tp,
  input  logic [Width-1:0]       s_in,
  input  logic                   cout_in,
  output logic [Width-1:0]       res,
  output logic                   res_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  input  logic                   abort,
  output logic                   aborted
);
  localparam int IW = $clog2(Pulse_Width);
  typedef enum logic [1:0] {IDLE, PULSE, CAPTURE, HOLD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic gap_q, gap_d, pulse_on;
  logic [Pulse_Width-1:0] tp_q, tp_d;
  logic [Width-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic op_ca_q, op_ca_d, res_cout_q, res_cout_d, aborted_q, aborted_d;
  logic last_hold, last_idx;
  assign last_hold = cnt_q == 4'(PULSE_LEN-1);
  assign last_idx = idx_q == IW'(Pulse_Width-1);
  // tp is rebuilt from the next index so it stays a clean registered one-hot
  assign tp_d = pulse_on ? {{(Pulse_Width-1){1'b0}}, 1'b1} << idx_d : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= 1'b0;
      tp_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_ca_q    <= 1'b0;
      res_q      <= '0;
      res_cout_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      tp_q       <= tp_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_ca_q    <= op_ca_d;
      res_q      <= res_d;
      res_cout_q <= res_cout_d;
      aborted_q  <= aborted_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_ca_d    = op_ca_q;
    res_d      = res_q;
    res_cout_d = res_cout_q;
    aborted_d  = 1'b0;
    pulse_on   = 1'b0;
    case (state_q)
      IDLE: if (start && !busy) begin
        state_d  = PULSE;
        op_a_d   = a_in;
        op_b_d   = b_in;
        op_ca_d  = ca_in;
        idx_d    = '0;
        cnt_d    = '0;
        gap_d    = 1'b0;
        pulse_on = 1'b1;
      end
      PULSE: if (abort) begin
        state_d   = IDLE;
        gap_d     = 1'b0;
        aborted_d = 1'b1;
      end else if (gap_q) begin
        gap_d    = 1'b0;
        pulse_on = 1'b1;
      end else if (!last_hold) begin
        cnt_d    = cnt_q + 4'd1;
        pulse_on = 1'b1;
      end else if (last_idx) begin
        cnt_d   = '0;
        state_d = CAPTURE;
      end else begin
        cnt_d = '0;
        idx_d = idx_q + IW'(1);
`ifdef TWOSCOMP_SEQ_GAP_EN
        gap_d = 1'b1;
`else
        pulse_on = 1'b1;
`endif
      end
      CAPTURE: if (abort) begin
        state_d   = IDLE;
        aborted_d = 1'b1;
      end else begin
        res_d      = s_in;
        res_cout_d = cout_in;
        state_d    = HOLD;
      end
      HOLD: state_d = res_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy      = state_q != IDLE;
    res_valid = state_q == HOLD;
  end
  assign tp       = tp_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_ca    = op_ca_q;
  assign res      = res_q;
  assign res_cout = res_cout_q;
  assign aborted  = aborted_q;
endmodule

// File: tb/tb_twoscomp_pulse_seq.sv
// tb_twoscomp_pulse_seq: vector table, hand sequences and random ops against a timeline model of the pulse sequencer.
module tb_twoscomp_pulse_seq;
  localparam int W = 4, PW = 21*W, PL = 1, PL3 = 3;
`ifdef TWOSCOMP_SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  localparam int PER = GAP ? PL+1 : PL;
  localparam int P = GAP ? PW*(PL+1)-1 : PW*PL;
  localparam int P3 = GAP ? PW*(PL3+1)-1 : PW*PL3;
  typedef struct {
    logic [W-1:0] a, b;
    logic ca;
    int abort_at, ready_delay;
    bit keep_start;
    logic [W-1:0] exp_res;
    logic exp_cout;
  } vec_t;
  logic clk = 1'b0;
  logic rst, start, ca_in, abort, res_ready;
  logic [W-1:0] a_in, b_in;
  logic [W-1:0] op_a, op_b, s_in, res, op_a3, op_b3, s_in3, res3;
  logic op_ca, cout_in, res_cout, busy, res_valid, aborted;
  logic op_ca3, cout_in3, res_cout3, busy3, res_valid3, aborted3;
  logic [PW-1:0] tp, tp3;
  int checks = 0, failures = 0;
  logic [W-1:0] last_res;
  logic last_cout;
  vec_t vecs[9];
  always #5 clk = ~clk;
  always_comb {cout_in, s_in} = {1'b0, op_a} + {1'b0, ~op_b} + 5'(op_ca) + 5'd1;
  always_comb {cout_in3, s_in3} = {1'b0, op_a3} + {1'b0, ~op_b3} + 5'(op_ca3) + 5'd1;
  twoscomp_pulse_seq #(.Width(W), .PULSE_LEN(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .a_in(a_in), .b_in(b_in), .ca_in(ca_in),
    .op_a(op_a), .op_b(op_b), .op_ca(op_ca), .tp(tp), .s_in(s_in), .cout_in(cout_in),
    .res(res), .res_cout(res_cout), .res_valid(res_valid), .res_ready(res_ready),
    .abort(abort), .aborted(aborted));
  twoscomp_pulse_seq #(.Width(W), .PULSE_LEN(PL3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy3), .a_in(a_in), .b_in(b_in), .ca_in(ca_in),
    .op_a(op_a3), .op_b(op_b3), .op_ca(op_ca3), .tp(tp3), .s_in(s_in3), .cout_in(cout_in3),
    .res(res3), .res_cout(res_cout3), .res_valid(res_valid3), .res_ready(res_ready),
    .abort(abort), .aborted(aborted3));
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // cycle k after acceptance: pulse bit k/period, dark during the gap slot
  function automatic logic [PW-1:0] exp_tp(input int k);
    logic [PW-1:0] one = 1;
    return (k % PER < PL) ? one << (k / PER) : '0;
  endfunction
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ca);
    int r = int'(a) - int'(b) + int'(ca) + (1 << W);
    return (W+1)'(r);
  endfunction
  task automatic run_op(input vec_t v);
    int nbad;
    string info;
    logic [PW-1:0] e;
    logic [W-1:0] na;
    nbad = 0;
    info = "tp_walk";
    na = ~v.a;
    a_in = v.a; b_in = v.b; ca_in = v.ca; start = 1'b1;
    tick();
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); ca_in = 1'($urandom);
    for (int k = 0; k <= P; k++) begin
      e = k < P ? exp_tp(k) : '0;
      if (tp !== e || busy !== 1'b1 || res_valid !== 1'b0 || aborted !== 1'b0 ||
          op_a !== v.a || op_b !== v.b || op_ca !== v.ca) begin
        if (nbad == 0) info = $sformatf("tp_walk(k=%0d tp=%0h exp=%0h busy=%0b)", k, tp, e, busy);
        nbad++;
      end
      if (k == v.abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk(info, nbad, 0);
        chk("abort_tp", tp, 0);
        chk("abort_flag", aborted, 1);
        chk("abort_busy", busy, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_res", {res_cout, res}, {last_cout, last_res});
        tick();
        chk("aborted_1cyc", aborted, 0);
        chk("abort_no_valid", res_valid, 0);
        return;
      end
      tick();
    end
    chk(info, nbad, 0);
    chk("res_valid_rise", res_valid, 1);
    chk("res", res, v.exp_res);
    chk("res_cout", res_cout, v.exp_cout);
    chk("hold_busy", busy, 1);
    last_res = v.exp_res;
    last_cout = v.exp_cout;
    if (v.keep_start) begin
      start = 1'b1;
      a_in = na;
    end
    nbad = 0;
    for (int d = 0; d < v.ready_delay; d++) begin
      abort = d == 0;
      tick();
      if (res_valid !== 1'b1 || busy !== 1'b1 || aborted !== 1'b0 || res !== v.exp_res || op_a !== v.a) nbad++;
    end
    abort = 1'b0;
    if (v.ready_delay > 0) chk("hold_stable", nbad, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("handshake_valid_drop", res_valid, 0);
    chk("handshake_busy_drop", busy, 0);
    chk("res_held", {res_cout, res}, {v.exp_cout, v.exp_res});
    if (v.keep_start) begin
      tick();
      chk("accept_after_idle", busy, 1);
      chk("new_op_a", op_a, na);
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("cleanup_abort", aborted, 1);
      tick();
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int lat, hi;
    vec_t rv;
    vecs[0] = '{4'd9,  4'd3,  1'b0, -1,       0,  1'b0, 4'd6,  1'b1};
    vecs[1] = '{4'd5,  4'd7,  1'b0, -1,       2,  1'b0, 4'd14, 1'b0};
    vecs[2] = '{4'd0,  4'd0,  1'b0, -1,       1,  1'b0, 4'd0,  1'b1};
    vecs[3] = '{4'd15, 4'd1,  1'b1, -1,       0,  1'b0, 4'd15, 1'b1};
    vecs[4] = '{4'd4,  4'd9,  1'b0, 40*PER,   0,  1'b0, 4'd0,  1'b0};
    vecs[5] = '{4'd7,  4'd2,  1'b0, -1,       10, 1'b1, 4'd5,  1'b1};
    vecs[6] = '{4'd3,  4'd3,  1'b0, P-1,      0,  1'b0, 4'd0,  1'b0};
    vecs[7] = '{4'd2,  4'd1,  1'b0, P,        0,  1'b0, 4'd0,  1'b0};
    vecs[8] = '{4'd0,  4'd15, 1'b1, -1,       0,  1'b0, 4'd2,  1'b0};
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; ca_in = 1'b0;
    abort = 1'b0; res_ready = 1'b0; last_res = '0; last_cout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tp", tp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_res", {res_cout, res}, 0);
    chk("rst_ops", {op_ca, op_a, op_b}, 0);
    chk("rst_aborted", aborted, 0);
    rst = 1'b0;
    tick();
    chk("idle_tp", tp, 0);
    a_in = 4'd9; b_in = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("pl3_accept", {busy3, tp3[0]}, 2'b11);
    lat = -1;
    hi = 0;
    for (int n = 0; n < 2000 && lat < 0; n++) begin
      if (res_valid3) lat = n;
      else begin
        if (tp3[5]) hi++;
        tick();
      end
    end
    chk("pl3_tp5_len", hi, PL3);
    chk("pl3_valid_lat", lat, P3+1);
    chk("pl3_res", {res_cout3, res3}, 5'h16);
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    foreach (vecs[i]) run_op(vecs[i]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ignored", {aborted, busy}, 0);
    a_in = 4'd1; b_in = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20*PER) tick();
    chk("pre_rst_tp", tp, exp_tp(20*PER));
    rst = 1'b1;
    #1;
    chk("async_rst_tp", tp, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", res_valid, 0);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_tp", tp, 0);
    chk("post_rst_busy", busy, 0);
    last_res = '0;
    last_cout = 1'b0;
    run_op('{4'd5, 4'd7, 1'b0, -1, 1, 1'b0, 4'd14, 1'b0});
    for (int i = 0; i < 12; i++) begin
      rv.a = W'($urandom);
      rv.b = W'($urandom);
      rv.ca = 1'($urandom);
      rv.abort_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, P)) : -1;
      rv.ready_delay = int'($urandom_range(0, 3));
      rv.keep_start = 1'b0;
      {rv.exp_cout, rv.exp_res} = model(rv.a, rv.b, rv.ca);
      run_op(rv);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
